result_tx_sequencer: RTL and testbench

//  Drains the Calculator's packed result bus to uart_tx in SEND_RESULT. Snapshots the

---
 rtl/result_tx_sequencer_if.sv | 24 ++
 rtl/result_tx_sequencer.sv | 122 ++++++++++++
 tb/tb_result_tx_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_tx_sequencer_if.sv
// rtl/result_tx_sequencer_if.sv - control/uart-side handshake bundle for result_tx_sequencer
interface result_tx_sequencer_if #(
    parameter int MAX_N  = 10,
    parameter int ELEM_W = 16
);
    logic                            start;
    logic [3:0]                      matrix_size;
    logic [MAX_N*MAX_N*ELEM_W-1:0]   result;
    logic                            tx_busy;
    logic                            tx_start;
    logic [7:0]                      tx_data;
    logic                            busy;
    logic                            done;

    modport master (
        output start, matrix_size, result, tx_busy,
        input  tx_start, tx_data, busy, done
    );

    modport slave (
        input  start, matrix_size, result, tx_busy,
        output tx_start, tx_data, busy, done
    );
endinterface

// File: rtl/result_tx_sequencer.sv
// rtl/result_tx_sequencer.sv - streams the active NxN result elements to uart_tx, MSB byte first
module result_tx_sequencer #(
    parameter int MAX_N  = 10,
    parameter int ELEM_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    result_tx_sequencer_if.slave   bus
);
    localparam int NE = MAX_N * MAX_N;

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [NE*ELEM_W-1:0]   snap_q, snap_d;
    logic [3:0]             n_q, n_d;
    logic [3:0]             row_q, row_d;
    logic [3:0]             col_q, col_d;
    logic                   hi_q, hi_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [6:0]             idx;
    logic [ELEM_W-1:0]      elem;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        n_d     = n_q;
        row_d   = row_q;
        col_d   = col_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.result;
                    n_d     = (bus.matrix_size > 4'(MAX_N)) ? 4'(MAX_N) : bus.matrix_size;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                row_d   = 4'd0;
                col_d   = 4'd0;
                hi_d    = 1'b1;
                state_d = (n_q == 4'd0) ? FINISH : ISSUE;
            end
            // The launch pulse is raised on the edge into (or while waiting in) ISSUE,
            // so ISSUE only has to retire once the registered pulse has been seen.
            ISSUE: begin
                if (tx_start_q) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_d = NEXT;
            end
            NEXT: begin
                if (hi_q) begin
                    hi_d    = 1'b0;
                    state_d = ISSUE;
                end else if (row_q == n_q - 4'd1 && col_q == n_q - 4'd1) begin
                    hi_d    = 1'b1;
                    state_d = FINISH;
                end else begin
                    hi_d    = 1'b1;
                    state_d = ISSUE;
                    if (col_q == n_q - 4'd1) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Byte select uses next-state counters so data is valid alongside the early pulse.
        idx        = 7'(32'(row_d) * MAX_N + 32'(col_d));
        elem       = snap_q[32'(idx)*ELEM_W +: ELEM_W];
        tx_start_d = (state_d == ISSUE) && !tx_start_q && !bus.tx_busy;
        tx_data_d  = tx_start_d ? (hi_d ? elem[15:8] : elem[7:0]) : tx_data_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == FINISH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            n_q        <= 4'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            hi_q       <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            hi_q       <= hi_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_result_tx_sequencer.sv
// tb/tb_result_tx_sequencer.sv - randomized self-checking bench with a uart_tx responder model
module tb_result_tx_sequencer;
    localparam int MAX_N  = 10;
    localparam int ELEM_W = 16;

    logic clk;
    logic rst;

    result_tx_sequencer_if #(.MAX_N(MAX_N), .ELEM_W(ELEM_W)) u_if ();

    result_tx_sequencer #(.MAX_N(MAX_N), .ELEM_W(ELEM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [15:0] elems [MAX_N*MAX_N];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    int          done_cnt;
    int          d0;
    int          busy_cnt;
    int          fixed_len;
    logic        ext_hold;
    logic [7:0]  held;
    logic        hold_chk;

    // Behaves like uart_tx: busy for a few cycles per launched byte; also watches protocol rules.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst && u_if.tx_start) begin
                checks++;
                if (u_if.tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_start_while_busy: tx_busy=%b required 0", u_if.tx_busy);
                end
                got.push_back(u_if.tx_data);
                held     = u_if.tx_data;
                hold_chk = 1'b1;
                busy_cnt = (fixed_len > 0) ? fixed_len : int'($urandom_range(2, 6));
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (!rst) hold_chk = 1'b0;
                else if (hold_chk) begin
                    if (u_if.tx_busy) begin
                        checks++;
                        if (u_if.tx_data !== held) begin
                            errors++;
                            $display("FAIL tx_data_stable: got %h required %h", u_if.tx_data, held);
                        end
                    end else hold_chk = 1'b0;
                end
            end
            if (u_if.done === 1'b1) begin
                done_cnt++;
                checks++;
                if (u_if.tx_start !== 1'b0) begin
                    errors++;
                    $display("FAIL done_with_tx_start: tx_start=%b required 0", u_if.tx_start);
                end
            end
            u_if.tx_busy = (busy_cnt > 0) || ext_hold;
        end
    endtask

    task automatic pack_result();
        for (int k = 0; k < MAX_N*MAX_N; k++) u_if.result[k*16 +: 16] = elems[k];
    endtask

    task automatic pulse_start(input logic [3:0] n);
        @(posedge clk); #1;
        u_if.start       = 1'b1;
        u_if.matrix_size = n;
        @(posedge clk); #1;
        u_if.start       = 1'b0;
    endtask

    task automatic start_xfer(input int n);
        int nn;
        nn = (n > MAX_N) ? MAX_N : n;
        pack_result();
        exp_q.delete();
        for (int r = 0; r < nn; r++)
            for (int c = 0; c < nn; c++) begin
                exp_q.push_back(elems[r*MAX_N + c][15:8]);
                exp_q.push_back(elems[r*MAX_N + c][7:0]);
            end
        got.delete();
        d0 = done_cnt;
        pulse_start(4'(n));
    endtask

    task automatic finish_xfer(input string name);
        int lim;
        for (int i = 0; i < 8000 && done_cnt == d0; i++) @(negedge clk);
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_timeout: done not seen, bytes got %0d required %0d", name, got.size(), exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt - d0);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_byte_count: got %0d required %0d", name, got.size(), exp_q.size());
        end
        lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte[%0d]: got %h required %h", name, i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({u_if.tx_start, u_if.tx_data, u_if.busy, u_if.done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {u_if.tx_start, u_if.tx_data, u_if.busy, u_if.done});
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'h5A5A;
        elems[0] = 16'h1234; elems[1] = 16'hABCD; elems[10] = 16'h0001; elems[11] = 16'hFFFF;
        start_xfer(2);
        checks++;
        if (u_if.busy !== 1'b1 || u_if.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_cycle1: busy=%b tx_start=%b required 1/0", u_if.busy, u_if.tx_start);
        end
        @(posedge clk); #1;
        checks++;
        if (u_if.tx_start !== 1'b1 || u_if.tx_data !== 8'h12) begin
            errors++;
            $display("FAIL basic_first_launch: tx_start=%b data=%h required 1/12", u_if.tx_start, u_if.tx_data);
        end
        finish_xfer("basic");
    endtask

    task automatic test_zero();
        logic [1:0] obs [4];
        logic [1:0] req [4];
        req = '{2'b10, 2'b10, 2'b01, 2'b00};
        got.delete();
        pulse_start(4'd0);
        for (int i = 0; i < 4; i++) begin
            obs[i] = {u_if.busy, u_if.done};
            checks++;
            if (obs[i] !== req[i]) begin
                errors++;
                $display("FAIL zero_cycle%0d: busy,done=%b required %b", i + 1, obs[i], req[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL zero_no_bytes: got %0d required 0", got.size());
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'(k);
        start_xfer(12);
        finish_xfer("full");
        checks++;
        if (got.size() != 200 || got[198] !== 8'h00 || got[199] !== 8'h63) begin
            errors++;
            $display("FAIL full_last_pair: size %0d required 200 with last pair 00 63", got.size());
        end
    endtask

    task automatic test_snapshot();
        for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'($urandom);
        start_xfer(3);
        repeat (6) @(posedge clk);
        for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'($urandom);
        pack_result();
        pulse_start(4'd5);
        finish_xfer("snapshot");
    endtask

    task automatic test_busy_hold();
        for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'($urandom);
        ext_hold = 1'b1;
        @(posedge clk); #1;
        start_xfer(1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (u_if.tx_start !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_launch[%0d]: tx_start=%b required 0", i, u_if.tx_start);
            end
            @(posedge clk); #1;
        end
        ext_hold = 1'b0;
        finish_xfer("hold");
    endtask

    task automatic test_abort();
        int n_before;
        for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'($urandom);
        elems[1]  = 16'hA55A;
        fixed_len = 8;
        start_xfer(2);
        for (int i = 0; i < 500 && got.size() < 3; i++) @(negedge clk);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL abort_reach_byte3: got %0d required 3", got.size());
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({u_if.tx_start, u_if.tx_data, u_if.busy, u_if.done} !== 11'd0) begin
            errors++;
            $display("FAIL abort_async_clear: got %b required 0", {u_if.tx_start, u_if.tx_data, u_if.busy, u_if.done});
        end
        n_before = got.size();
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        checks++;
        if (got.size() != n_before) begin
            errors++;
            $display("FAIL abort_no_more_bytes: got %0d required %0d", got.size(), n_before);
        end
        fixed_len = 0;
        start_xfer(1);
        finish_xfer("after_abort");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < MAX_N*MAX_N; k++) elems[k] = 16'($urandom);
            start_xfer(int'($urandom_range(1, 15)));
            finish_xfer("random");
        end
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0; busy_cnt = 0; fixed_len = 0;
        ext_hold = 1'b0; hold_chk = 1'b0; held = 8'd0;
        rst = 1'b0;
        u_if.start = 1'b0; u_if.matrix_size = 4'd0; u_if.result = '0; u_if.tx_busy = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        test_reset();
        #2 rst = 1'b1;
        test_basic();
        test_zero();
        test_full();
        test_snapshot();
        test_busy_hold();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
